// File: rtl/alu_cmd_pkg.sv
// alu_cmd_pkg: shared types for the ALU command driver.
//   OP_* : 3-bit ALU opcodes
//   state_t : driver FSM states
//   cmd_t : one queued command {a, b, op}
package alu_cmd_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_NAND = 3'd7;

  typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
  } cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous command FIFO, DEPTH entries (power of two).
//   clk, rst_n : clock, async active-low reset (empties the FIFO)
//   push, din  : write request/data, ignored when full
//   pop, dout  : read request/head entry, ignored when empty
//   full, empty: occupancy flags
// dout is the registered head entry; a write is only visible after its
// edge, so there is no fall-through path.
module alu_cmd_fifo
  import alu_cmd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  cmd_t din,
  input  logic pop,
  output cmd_t dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: queues ALU commands, drives each onto the ALU for SETTLE
// cycles, captures the result and offers it on a valid/ready port.
//   clk, rst_n                 : clock, async active-low reset
//   cmd_valid/ready, cmd_a/b/op: command input (ready = FIFO not full)
//   alu_a/b/sel, alu_y         : registered ALU operands, ALU result
//   res_valid/ready            : result handshake
//   res_y, res_op, res_dz      : captured result, its opcode, div-by-zero flag
// Build option: ALU_CMD_DRIVER_DIVZERO_EN -- DIV with b=0 is not driven onto
// the ALU and is reported as res_y=4'hF, res_dz=1. Otherwise res_dz stays 0.
module alu_cmd_driver
  import alu_cmd_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [2:0] cmd_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_sel,
  input  logic [3:0] alu_y,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_y,
  output logic [2:0] res_op,
  output logic       res_dz
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t        state, state_nxt;
  cmd_t          head, din;
  logic          full, empty;
  logic          pop, capture;
  logic          head_dz, dz_pend;
  logic [CW-1:0] cnt;
  logic [2:0]    cur_op;

  assign din       = '{a: cmd_a, b: cmd_b, op: cmd_op};
  assign cmd_ready = !full;
  // HOLD is entered exactly on capture and left on handshake.
  assign res_valid = (state == HOLD);

`ifdef ALU_CMD_DRIVER_DIVZERO_EN
  assign head_dz = (head.op == OP_DIV) && (head.b == 4'd0);
`else
  assign head_dz = 1'b0;
`endif

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid && cmd_ready),
    .din   (din),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop       = 1'b1;
        state_nxt = DRIVE;
      end
      DRIVE: if (cnt == '0) begin
        capture   = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: if (res_ready) begin
        // Chain straight into the next command to avoid an IDLE bubble.
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = DRIVE;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
      cnt     <= '0;
      cur_op  <= '0;
      dz_pend <= 1'b0;
      res_y   <= '0;
      res_op  <= '0;
      res_dz  <= 1'b0;
    end else begin
      if (pop) begin
        cnt     <= CW'(SETTLE - 1);
        // The opcode is kept separately: a suppressed DIV leaves alu_sel stale.
        cur_op  <= head.op;
        dz_pend <= head_dz;
        if (!head_dz) begin
          alu_a   <= head.a;
          alu_b   <= head.b;
          alu_sel <= head.op;
        end
      end else if (state == DRIVE && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (capture) begin
        res_y  <= dz_pend ? 4'hF : alu_y;
        res_op <= cur_op;
        res_dz <= dz_pend;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Self-checking bench for alu_cmd_driver: a behavioural ALU feeds the DUTs,
// and a queue-based reference model predicts every result from the
// arithmetic of each accepted command.
module tb_alu_cmd_driver;
  import alu_cmd_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       cmd_valid = 1'b0, cmd_valid3 = 1'b0;
  logic [3:0] cmd_a = '0, cmd_b = '0;
  logic [2:0] cmd_op = '0;
  logic       res_ready = 1'b0, res_ready3 = 1'b0;
  logic       cmd_ready, res_valid, res_dz;
  logic [3:0] alu_a, alu_b, alu_y, res_y;
  logic [2:0] alu_sel, res_op;
  logic       cmd_ready3, res_valid3, res_dz3;
  logic [3:0] alu_a3, alu_b3, alu_y3, res_y3;
  logic [2:0] alu_sel3, res_op3;

  int n_chk = 0, n_pass = 0;
  cmd_t q[$];

  // Reference arithmetic for a 4-bit ALU; a zero divisor yields 4'hF.
  function automatic logic [3:0] ref_y(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] op);
    int ia, ib, r;
    ia = int'(a); ib = int'(b);
    case (op)
      OP_ADD:  r = (ia + ib) % 16;
      OP_SUB:  r = (ia - ib + 16) % 16;
      OP_MUL:  r = (ia * ib) % 16;
      OP_DIV:  r = (ib == 0) ? 15 : ia / ib;
      OP_AND:  r = int'(a & b);
      OP_OR:   r = int'(a | b);
      OP_XOR:  r = int'(a ^ b);
      default: r = int'(~(a & b)) & 15;
    endcase
    return 4'(r);
  endfunction

  function automatic logic ref_dz(input logic [3:0] b, input logic [2:0] op);
`ifdef ALU_CMD_DRIVER_DIVZERO_EN
    return (op == OP_DIV) && (b == 4'd0);
`else
    return 1'b0;
`endif
  endfunction

  always_comb alu_y  = ref_y(alu_a, alu_b, alu_sel);
  always_comb alu_y3 = ref_y(alu_a3, alu_b3, alu_sel3);

  alu_cmd_driver #(.DEPTH(4), .SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_y(alu_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y),
    .res_op(res_op), .res_dz(res_dz)
  );

  alu_cmd_driver #(.DEPTH(4), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_sel(alu_sel3), .alu_y(alu_y3),
    .res_valid(res_valid3), .res_ready(res_ready3), .res_y(res_y3),
    .res_op(res_op3), .res_dz(res_dz3)
  );

  // Offer one command on the SETTLE=1 DUT; returns just after its edge.
  task automatic send1(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    @(negedge clk);
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Edges from acceptance until res_valid is seen; -1 on timeout.
  task automatic wait_res(output int lat);
    lat = -1;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk); #1;
      if (res_valid) begin lat = i; break; end
    end
  endtask

  task automatic consume();
    @(negedge clk); res_ready = 1'b1;
    @(posedge clk); #1; res_ready = 1'b0;
  endtask

  // Hold cmd_valid for n cycles, pushing each accepted command into q.
  task automatic fill(input int n, input bit rnd, output int acc);
    cmd_t pend;
    acc = 0;
    pend = '{a: 4'($urandom), b: 4'($urandom), op: 3'($urandom)};
    if (!rnd) pend = '{a: 4'd1, b: 4'd9, op: OP_XOR};
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cmd_a = pend.a; cmd_b = pend.b; cmd_op = pend.op; cmd_valid = 1'b1;
      if (cmd_ready) begin
        q.push_back(pend);
        acc++;
        pend = rnd ? '{a: 4'($urandom), b: 4'($urandom), op: 3'($urandom)}
                   : '{a: 4'(acc + 1), b: 4'(acc + 9), op: OP_XOR};
      end
    end
    @(negedge clk); cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b exp 0", res_valid); else n_pass++;
    n_chk++; if ({res_y, res_op, res_dz} !== 8'h00) $display("FAIL reset_res: got %h exp 00", {res_y, res_op, res_dz}); else n_pass++;
    n_chk++; if ({alu_a, alu_b, alu_sel} !== 11'h000) $display("FAIL reset_alu: got %h exp 000", {alu_a, alu_b, alu_sel}); else n_pass++;
    n_chk++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b exp 1", cmd_ready); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_ops();
    logic [3:0] ta [4] = '{4'd9, 4'd3, 4'd5, 4'hF};
    logic [3:0] tb [4] = '{4'd8, 4'd5, 4'd4, 4'hF};
    logic [2:0] to [4] = '{OP_ADD, OP_SUB, OP_MUL, OP_NAND};
    logic [3:0] te [4] = '{4'h1, 4'hE, 4'h4, 4'h0};
    int lat;
    for (int i = 0; i < 4; i++) begin
      send1(ta[i], tb[i], to[i]);
      wait_res(lat);
      n_chk++; if (lat != 2) $display("FAIL ops_latency[%0d]: got %0d exp 2", i, lat); else n_pass++;
      n_chk++; if (res_y !== te[i]) $display("FAIL ops_res_y[%0d]: got %h exp %h", i, res_y, te[i]); else n_pass++;
      n_chk++; if (res_op !== to[i]) $display("FAIL ops_res_op[%0d]: got %h exp %h", i, res_op, to[i]); else n_pass++;
      n_chk++; if (res_dz !== 1'b0) $display("FAIL ops_res_dz[%0d]: got %b exp 0", i, res_dz); else n_pass++;
      consume();
    end
  endtask

  task automatic test_divzero();
    int lat;
    send1(4'd3, 4'd5, OP_AND);
    wait_res(lat);
    consume();
    send1(4'd7, 4'd0, OP_DIV);
    wait_res(lat);
    n_chk++; if (lat != 2) $display("FAIL dz_latency: got %0d exp 2", lat); else n_pass++;
    n_chk++; if (res_op !== OP_DIV) $display("FAIL dz_res_op: got %h exp %h", res_op, OP_DIV); else n_pass++;
`ifdef ALU_CMD_DRIVER_DIVZERO_EN
    n_chk++; if (res_y !== 4'hF) $display("FAIL dz_res_y: got %h exp f", res_y); else n_pass++;
    n_chk++; if (res_dz !== 1'b1) $display("FAIL dz_flag: got %b exp 1", res_dz); else n_pass++;
    n_chk++; if (alu_sel !== OP_AND) $display("FAIL dz_alu_sel: got %h exp %h", alu_sel, OP_AND); else n_pass++;
`else
    n_chk++; if (res_dz !== 1'b0) $display("FAIL dz_flag: got %b exp 0", res_dz); else n_pass++;
    n_chk++; if (alu_sel !== OP_DIV) $display("FAIL dz_alu_sel: got %h exp %h", alu_sel, OP_DIV); else n_pass++;
`endif
    consume();
  endtask

  task automatic test_backpressure();
    int acc, last, got;
    cmd_t c;
    res_ready = 1'b0;
    q.delete();
    fill(10, 1'b1, acc);
    n_chk++; if (acc != 5) $display("FAIL bp_accepted: got %0d exp 5", acc); else n_pass++;
    n_chk++; if (cmd_ready !== 1'b0) $display("FAIL bp_cmd_ready: got %b exp 0", cmd_ready); else n_pass++;
    last = -1; got = 0;
    for (int cyc = 0; cyc < 40 && q.size() > 0; cyc++) begin
      if (cyc > 0) @(negedge clk);
      res_ready = 1'b1;
      if (res_valid) begin
        c = q.pop_front();
        got++;
        n_chk++; if (res_y !== ref_y(c.a, c.b, c.op)) $display("FAIL bp_res_y[%0d]: got %h exp %h", got, res_y, ref_y(c.a, c.b, c.op)); else n_pass++;
        n_chk++; if (res_op !== c.op) $display("FAIL bp_res_op[%0d]: got %h exp %h", got, res_op, c.op); else n_pass++;
        if (last >= 0) begin
          n_chk++; if (cyc - last != 2) $display("FAIL bp_interval[%0d]: got %0d exp 2", got, cyc - last); else n_pass++;
        end
        last = cyc;
      end
    end
    n_chk++; if (got != 5) $display("FAIL bp_drained: got %0d exp 5", got); else n_pass++;
    @(negedge clk); res_ready = 1'b0;
    q.delete();
  endtask

  task automatic test_random();
    localparam int N = 40;
    int got = 0;
    res_ready = 1'b0;
    q.delete();
    fork
      begin : drv
        cmd_t pend;
        int guard = 0;
        for (int i = 0; i < N && guard < 3000; i++) begin
          pend.a  = 4'($urandom);
          pend.b  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
          pend.op = 3'($urandom);
          do begin
            @(negedge clk);
            guard++;
            cmd_a = pend.a; cmd_b = pend.b; cmd_op = pend.op;
            cmd_valid = ($urandom_range(0, 3) != 0);
          end while (!(cmd_valid && cmd_ready) && guard < 3000);
          if (cmd_valid && cmd_ready) q.push_back(pend);
        end
        @(negedge clk); cmd_valid = 1'b0;
      end
      begin : mon
        cmd_t c;
        for (int cyc = 0; cyc < 4000 && got < N; cyc++) begin
          @(negedge clk);
          res_ready = $urandom_range(0, 1) != 0;
          if (res_valid && res_ready && q.size() > 0) begin
            c = q.pop_front();
            got++;
            n_chk++; if (res_y !== ref_y(c.a, c.b, c.op)) $display("FAIL rnd_res_y[%0d]: got %h exp %h", got, res_y, ref_y(c.a, c.b, c.op)); else n_pass++;
            n_chk++; if (res_op !== c.op) $display("FAIL rnd_res_op[%0d]: got %h exp %h", got, res_op, c.op); else n_pass++;
            n_chk++; if (res_dz !== ref_dz(c.b, c.op)) $display("FAIL rnd_res_dz[%0d]: got %b exp %b", got, res_dz, ref_dz(c.b, c.op)); else n_pass++;
          end
        end
      end
    join
    n_chk++; if (got != N) $display("FAIL rnd_count: got %0d exp %0d", got, N); else n_pass++;
    @(negedge clk); res_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int acc, lat;
    res_ready = 1'b0;
    q.delete();
    fill(8, 1'b0, acc);
    // One handshake moves the second command into DRIVE with three queued.
    res_ready = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0; res_ready = 1'b0;
    #1;
    n_chk++; if (res_valid !== 1'b0) $display("FAIL rmid_res_valid: got %b exp 0", res_valid); else n_pass++;
    n_chk++; if ({res_y, res_op, res_dz} !== 8'h00) $display("FAIL rmid_res: got %h exp 00", {res_y, res_op, res_dz}); else n_pass++;
    n_chk++; if ({alu_a, alu_b, alu_sel} !== 11'h000) $display("FAIL rmid_alu: got %h exp 000", {alu_a, alu_b, alu_sel}); else n_pass++;
    n_chk++; if (cmd_ready !== 1'b1) $display("FAIL rmid_cmd_ready: got %b exp 1", cmd_ready); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_chk++; if (res_valid !== 1'b0) $display("FAIL rmid_stale: got %b exp 0", res_valid); else n_pass++;
    q.delete();
    send1(4'd2, 4'd3, OP_ADD);
    wait_res(lat);
    n_chk++; if (lat != 2 || res_y !== 4'd5) $display("FAIL rmid_fresh: got lat %0d y %h exp lat 2 y 5", lat, res_y); else n_pass++;
    consume();
  endtask

  task automatic test_settle3();
    int lat = -1;
    @(negedge clk);
    cmd_a = 4'd6; cmd_b = 4'd3; cmd_op = OP_SUB; cmd_valid3 = 1'b1;
    @(posedge clk); #1;
    cmd_valid3 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (res_valid3) begin lat = i; break; end
      if (i <= 3) begin
        n_chk++; if ({alu_a3, alu_b3, alu_sel3} !== {4'd6, 4'd3, OP_SUB}) $display("FAIL s3_alu[%0d]: got %h exp %h", i, {alu_a3, alu_b3, alu_sel3}, {4'd6, 4'd3, OP_SUB}); else n_pass++;
      end
    end
    n_chk++; if (lat != 4) $display("FAIL s3_latency: got %0d exp 4", lat); else n_pass++;
    n_chk++; if ({res_y3, res_op3, res_dz3} !== {4'd3, OP_SUB, 1'b0}) $display("FAIL s3_res: got %h exp %h", {res_y3, res_op3, res_dz3}, {4'd3, OP_SUB, 1'b0}); else n_pass++;
    @(negedge clk); res_ready3 = 1'b1;
    @(posedge clk); #1; res_ready3 = 1'b0;
    n_chk++; if (res_valid3 !== 1'b0) $display("FAIL s3_release: got %b exp 0", res_valid3); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_ops();
    test_divzero();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_settle3();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/alu_cmd_driver.md
# alu_cmd_driver

Sequential initiator for the 4-bit combinational ALU (operands a/b, 3-bit opcode sel, result y). It accepts operation commands over a valid/ready interface and buffers them in a small FIFO. It drives each command's operands and opcode onto the ALU for a fixed settle window, then captures the ALU result and presents it on a valid/ready result port. It sits between a command source (test sequencer or controller) and the ALU instance.

## Interface
- DEPTH, 4, command FIFO entries (power of two, ≥2)
- SETTLE, 1, cycles operands are held on the ALU before y is sampled (≥1)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready; equals !fifo_full
- cmd_a, cmd_b  input  4  operands
- cmd_op  input  3  opcode: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR, 110 XOR, 111 NAND
- alu_a, alu_b  output  4  registered operands to ALU
- alu_sel  output  3  registered opcode to ALU
- alu_y  input  4  ALU result
- res_valid  output  1  result available
- res_ready  input  1  result consumed when res_valid && res_ready
- res_y  output  4  captured result
- res_op  output  3  opcode of the result
- res_dz  output  1  divide-by-zero flag (see Configuration)

## Operation
- FSM states: IDLE, DRIVE, HOLD.
- IDLE with FIFO non-empty: pop the head, load alu_a/alu_b/alu_sel, load the settle counter with SETTLE-1, go to DRIVE.
- DRIVE: decrement the counter. When it reaches 0, register alu_y into res_y and the opcode into res_op, set res_valid, go to HOLD.
- HOLD: res_valid stays high, and res_y/res_op/res_dz stay stable until the handshake.
  - On handshake with FIFO non-empty: pop the next command straight into DRIVE (no IDLE bubble).
  - On handshake with FIFO empty: go to IDLE and clear res_valid.
- alu_a/alu_b/alu_sel hold their last value outside DRIVE.
- Width rule: results are 4 bits, taken as the ALU delivers them (ADD/SUB/MUL mod 16, DIV quotient). The driver performs no arithmetic.
- FIFO boundary conditions:
  - Push and pop in the same cycle are allowed when not full.
  - When full, cmd_ready is 0 even if a pop occurs that cycle (no bypass).
  - Empty FIFO has no fall-through; an accepted command is never issued in its acceptance cycle.
  - Pointers wrap modulo DEPTH.
- Reset: asynchronous and immediate, including mid-operation.
  - FIFO emptied, in-flight operation discarded, state IDLE.
  - alu_a/alu_b/alu_sel/res_y/res_op = 0; res_valid = 0; res_dz = 0; cmd_ready = 1.

## Timing
- Command accepted at edge t0 → popped and driven on the ALU at t1 → captured at t1+SETTLE.
- res_valid is high in the cycle after edge t1+SETTLE: latency SETTLE+1 edges (2 at default).
- With res_ready held high, throughput is one result per SETTLE+1 cycles.
- In-flight capacity is DEPTH+1 (FIFO plus the HOLD register).
- cmd_ready is combinational from the FIFO count only, never from cmd_valid.

## Configuration
- ALU_CMD_DRIVER_DIVZERO_EN defined:
  - DIV with b=0 is not driven onto the ALU (alu_* unchanged).
  - DRIVE still lasts SETTLE cycles.
  - Capture forces res_y=4'hF and res_dz=1.
  - All other captures set res_dz=0.
- Not defined: res_dz tied 0, and DIV with b=0 passes to the ALU like any other command.

## Structure
- Shared package alu_cmd_pkg:
  - opcode constants OP_ADD…OP_NAND (3-bit)
  - FSM state enum
  - command struct {a, b, op}
- Sub-module alu_cmd_fifo: synchronous FIFO parameterised on DEPTH, with full/empty outputs and async active-low reset.

## Test plan
- ADD 9+8 → res_y=4'h1, res_op=000, res_valid two cycles after acceptance (SETTLE=1).
- SUB 3−5 → res_y=4'hE; MUL 5×4 → res_y=4'h4; NAND 4'hF,4'hF → res_y=4'h0.
- DIV 7/0:
  - macro defined → res_y=4'hF, res_dz=1, alu_sel keeps its prior value.
  - undefined → res_dz=0.
- Backpressure, res_ready=0, six commands offered: five accepted; cmd_ready low from the sixth. Releasing res_ready drains results in order, back-to-back every 2 cycles.
- Reset asserted during DRIVE with 3 queued commands → all outputs at reset values immediately, cmd_ready=1, no stale result after release.
- SETTLE=3: alu_* stable for 3 cycles before capture, latency 4 edges.
